// File: rtl/status_event_if.sv
// Event-in / word-out bundle between the condition-match stage, the event FIFO
// and its valid/ready sink, plus the FIFO's occupancy and drop status.
interface status_event_if #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int CW    = 8
);
    logic                     ev_valid;
    logic [DW-1:0]            ev_data;
    logic                     clear;
    logic                     out_valid;
    logic [DW-1:0]            out_data;
    logic                     out_ready;
    logic [$clog2(DEPTH):0]   count;
    logic                     full;
    logic                     overflow;
    logic [CW-1:0]            drop_cnt;

    // Producer/sink side: raises events, flushes, accepts words.
    modport master (
        output ev_valid, ev_data, clear, out_ready,
        input  out_valid, out_data, count, full, overflow, drop_cnt
    );

    // FIFO side.
    modport slave (
        input  ev_valid, ev_data, clear, out_ready,
        output out_valid, out_data, count, full, overflow, drop_cnt
    );
endinterface

// File: rtl/status_event_fifo.sv
// Small first-word-fall-through FIFO capturing match-stage events and handing
// them to a valid/ready sink in arrival order. Events arriving while full with
// no simultaneous pop are dropped and tallied in a saturating counter.
module status_event_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int CW    = 8
) (
    input  logic        clk,
    input  logic        rst,
    status_event_if.slave bus
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CNTW = AW + 1;

    logic [DW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CNTW-1:0] cnt;
    logic [CNTW-1:0] cnt_nxt;
    logic            valid_r;
    logic            full_r;
    logic            ovf_r;
    logic [CW-1:0]   drop_r;
    logic            push;
    logic            pop;
    logic            drop;

    // Handshake decode and next occupancy; a pop frees the slot a full-FIFO push needs.
    always_comb begin
        pop  = valid_r && bus.out_ready;
        push = bus.ev_valid && (!full_r || pop);
        drop = bus.ev_valid && !push;
        cnt_nxt = cnt;
        case ({push, pop})
            2'b10:   cnt_nxt = cnt + CNTW'(1);
            2'b01:   cnt_nxt = cnt - CNTW'(1);
            default: cnt_nxt = cnt;
        endcase
    end

    // Storage write; not reset, and an event coinciding with a flush is discarded.
    always_ff @(posedge clk) begin
        if (!rst && !bus.clear && push)
            mem[wr_ptr] <= bus.ev_data;
    end

    // Pointers, occupancy, and status flags; reset outranks clear, clear outranks push/pop.
    always_ff @(posedge clk) begin
        if (rst || bus.clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            valid_r <= 1'b0;
            full_r  <= 1'b0;
            ovf_r   <= 1'b0;
            drop_r  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            cnt     <= cnt_nxt;
            valid_r <= (cnt_nxt != '0);
            full_r  <= (cnt_nxt == CNTW'(DEPTH));
            if (drop) begin
                ovf_r <= 1'b1;
                if (drop_r != '1) drop_r <= drop_r + CW'(1);
            end
        end
    end

    // Head word comes straight off the registered read pointer: no path from ev_* or out_ready.
    assign bus.out_valid = valid_r;
    assign bus.out_data  = mem[rd_ptr];
    assign bus.count     = cnt;
    assign bus.full      = full_r;
    assign bus.overflow  = ovf_r;
    assign bus.drop_cnt  = drop_r;
endmodule

// File: tb/tb_status_event_fifo.sv
// Bench for status_event_fifo: directed scenarios plus random traffic. The
// stimulus side keeps a queue of words the FIFO should hold; a monitor on the
// falling edge checks status against it and pops/compares on every handshake.
module tb_status_event_fifo;
    localparam int DEPTH = 4;
    localparam int DW    = 32;
    localparam int CW    = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    status_event_if #(.DEPTH(DEPTH), .DW(DW), .CW(CW)) bus ();

    status_event_fifo #(.DEPTH(DEPTH), .DW(DW), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DW-1:0] exp_q[$];
    int  m_drop = 0;
    bit  m_ovf  = 0;
    bit  armed  = 0;
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Drive one cycle's inputs (called 1 time unit after a rising edge), decide
    // what the FIFO must do at the next edge, then apply that to the model.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic r,
                        input logic c, input logic rs);
        bit flush, m_pop, m_push;
        bus.ev_valid  = v;
        bus.ev_data   = d;
        bus.out_ready = r;
        bus.clear     = c;
        rst           = rs;
        flush  = rs || c;
        m_pop  = (exp_q.size() > 0) && r;
        m_push = v && ((exp_q.size() < DEPTH) || m_pop);
        @(posedge clk);
        if (flush) begin
            exp_q.delete();
            m_ovf  = 0;
            m_drop = 0;
        end else begin
            if (m_push) exp_q.push_back(d);
            if (v && !m_push) begin
                m_ovf = 1;
                if (m_drop < (1 << CW) - 1) m_drop++;
            end
        end
        armed = 1;
        #1;
    endtask

    // Monitor: status every cycle, head word whenever valid, pop on handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (armed) begin
                chk("out_valid", DW'(bus.out_valid), DW'(exp_q.size() > 0));
                chk("count",     DW'(bus.count),     DW'(exp_q.size()));
                chk("full",      DW'(bus.full),      DW'(exp_q.size() == DEPTH));
                chk("overflow",  DW'(bus.overflow),  DW'(m_ovf));
                chk("drop_cnt",  DW'(bus.drop_cnt),  DW'(m_drop));
                if (bus.out_valid === 1'b1 && exp_q.size() > 0)
                    chk("out_data", bus.out_data, exp_q[0]);
                if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1 && !rst && bus.clear !== 1'b1) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL pop_empty: DUT handshake with no expected word at %0t", $time);
                    end else begin
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        bus.ev_valid  = 1'b0;
        bus.ev_data   = '0;
        bus.out_ready = 1'b0;
        bus.clear     = 1'b0;
        @(posedge clk);
        #1;
        // Reset for two cycles, then idle.
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        repeat (2) step(0, 0, 1, 0, 0);

        // Single all-ones word, held, then accepted.
        step(1, 32'hFFFF_FFFF, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);

        // Five words into a four-deep FIFO: one drop.
        for (int i = 1; i <= 5; i++) step(1, DW'(i), 0, 0, 0);
        // Full with simultaneous pop: accepted, no drop.
        step(1, 32'd9, 1, 0, 0);
        repeat (5) step(0, 0, 1, 0, 0);

        // Steady push+pop: pointers wrap.
        step(1, 32'hA0, 0, 0, 0);
        for (int i = 1; i < 10; i++) step(1, 32'hA0 + DW'(i), 1, 0, 0);
        repeat (2) step(0, 0, 1, 0, 0);

        // Three entries with overflow pending, then clear alongside an event.
        for (int i = 0; i < 6; i++) step(1, 32'hC0 + DW'(i), 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(1, 32'hDEAD, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        // Same with reset.
        for (int i = 0; i < 6; i++) step(1, 32'hE0 + DW'(i), 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(1, 32'hBEEF, 0, 0, 1);
        step(0, 0, 0, 0, 0);

        // Drop counter saturation.
        for (int i = 0; i < 270; i++) step(1, DW'($urandom), 0, 0, 0);
        step(0, 0, 0, 1, 0);

        // Random traffic with occasional clear and reset.
        for (int i = 0; i < 2000; i++) begin
            int rc;
            rc = $urandom_range(0, 99);
            step($urandom_range(0, 99) < 60, DW'($urandom), $urandom_range(0, 99) < 50,
                 rc < 2, rc == 99);
        end
        repeat (6) step(0, 0, 1, 0, 0);

        armed = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
